inst_bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one INWIDTH-wide "ins" bus between NREQ requesters.
- Grants one requester at a time and registers that owner's data onto the shared bus.
- Releases on last beat, on request drop, or on a MAXHOLD forced preemption.
- Sits in front of the InstMod-style consumers that take an INWIDTH-wide ins bus, so multiple producers can drive a single instance.

---
 rtl/inst_bus_arbiter_if.sv | 39 +++
 rtl/inst_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_inst_bus_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_bus_arbiter_if.sv
// Shared ins-bus bundle: per-requester request/last/data in,
// registered grant, bus data and status out.
interface inst_bus_arbiter_if #(
  parameter int INWIDTH = 8,
  parameter int NREQ    = 4
);

  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         last;
  logic [NREQ*INWIDTH-1:0] data_in;
  logic [NREQ-1:0]         gnt;
  logic [INWIDTH-1:0]      ins;
  logic                    ins_vld;
  logic                    preempt;
  logic                    busy;

  modport master (
    output req,
    output last,
    output data_in,
    input  gnt,
    input  ins,
    input  ins_vld,
    input  preempt,
    input  busy
  );

  modport slave (
    input  req,
    input  last,
    input  data_in,
    output gnt,
    output ins,
    output ins_vld,
    output preempt,
    output busy
  );

endinterface

// File: rtl/inst_bus_arbiter.sv
// Round-robin arbiter that serialises NREQ producers onto one
// registered ins bus, with last/drop/MAXHOLD release and a gap cycle.
module inst_bus_arbiter #(
  parameter int INWIDTH = 8,
  parameter int NREQ    = 4,
  parameter int MAXHOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  inst_bus_arbiter_if.slave bus
);

  localparam int PW = $clog2(NREQ);
  localparam int HW = $clog2(MAXHOLD + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(MAXHOLD - 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [INWIDTH-1:0] ins_q, ins_d;
  logic               vld_q, vld_d;
  logic               pre_q, pre_d;

  logic               found;
  logic [PW-1:0]      win;
  logic [PW-1:0]      idx;
  logic               own_req;
  logic               own_last;
  logic [INWIDTH-1:0] own_data;
  logic [PW-1:0]      nxt_ptr;
  logic               rel;

  // first set request at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  assign own_req  = bus.req[owner_q];
  assign own_last = bus.last[owner_q];
  assign own_data = bus.data_in[owner_q*INWIDTH +: INWIDTH];
  assign nxt_ptr  = (owner_q == LAST_IDX) ? '0
                                          : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    ins_d   = ins_q;
    vld_d   = 1'b0;
    pre_d   = 1'b0;
    rel     = 1'b0;
    unique case (state_q)
      GRANT: begin
        if (own_req) begin
          ins_d  = own_data;
          vld_d  = 1'b1;
          hold_d = hold_q + 1'b1;
          if (own_last) begin
            rel = 1'b1;
          end else if (hold_q == HOLD_LAST) begin
            rel   = 1'b1;
            pre_d = 1'b1;
          end
        end else begin
          rel = 1'b1;
        end
        if (rel) begin
          state_d = GAP;
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
        end
      end
      default: begin
        gnt_d  = '0;
        hold_d = '0;
        if (found) begin
          state_d = GRANT;
          owner_d = win;
          gnt_d   = NREQ'(1) << win;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      ins_q   <= '0;
      vld_q   <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      ins_q   <= ins_d;
      vld_q   <= vld_d;
      pre_q   <= pre_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ins     = ins_q;
  assign bus.ins_vld = vld_q;
  assign bus.preempt = pre_q;
  assign bus.busy    = (state_q == GRANT);

  a_gnt_onehot: assert property (
    @(posedge clk) disable iff (reset)
    $onehot0(gnt_q));

  a_pre_in_gap: assert property (
    @(posedge clk) disable iff (reset)
    pre_q |-> (state_q == GAP));

  a_vld_after_grant: assert property (
    @(posedge clk) disable iff (reset)
    vld_q |-> ($past(state_q) == GRANT));

endmodule

// File: tb/tb_inst_bus_arbiter.sv
// Directed scenarios plus randomized traffic checked against
// a cycle-level model of the round-robin ins-bus arbiter.
module tb_inst_bus_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt = 0;
  int   total = 0;

  always #5 clk = ~clk;

  inst_bus_arbiter_if #(.INWIDTH(W), .NREQ(N)) bus ();

  inst_bus_arbiter #(
    .INWIDTH(W),
    .NREQ   (N),
    .MAXHOLD(MH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.req     = '0;
    bus.last    = '0;
    bus.data_in = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.gnt !== 4'b0000)
      $display("FAIL rst_gnt got %b want 0000", bus.gnt);
    else pass_cnt++;
    total++;
    if (bus.ins !== 8'h00)
      $display("FAIL rst_ins got %h want 00", bus.ins);
    else pass_cnt++;
    total++;
    if (bus.ins_vld !== 1'b0 || bus.preempt !== 1'b0 ||
        bus.busy !== 1'b0)
      $display("FAIL rst_flags got %b%b%b want 000",
               bus.ins_vld, bus.preempt, bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    bus.data_in = 32'h0000_00A5;
    bus.req     = 4'b0001;
    bus.last    = 4'b0001;
    tick();
    total++;
    if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1 ||
        bus.ins_vld !== 1'b0)
      $display("FAIL single_grant got gnt=%b busy=%b vld=%b want 0001/1/0",
               bus.gnt, bus.busy, bus.ins_vld);
    else pass_cnt++;
    tick();
    total++;
    if (bus.ins !== 8'hA5 || bus.ins_vld !== 1'b1)
      $display("FAIL single_beat got ins=%h vld=%b want a5/1",
               bus.ins, bus.ins_vld);
    else pass_cnt++;
    total++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0)
      $display("FAIL single_gap got gnt=%b busy=%b want 0000/0",
               bus.gnt, bus.busy);
    else pass_cnt++;
    bus.req  = '0;
    bus.last = '0;
    tick();
    total++;
    if (bus.gnt !== 4'b0000 || bus.ins_vld !== 1'b0 ||
        bus.busy !== 1'b0)
      $display("FAIL single_idle got gnt=%b vld=%b busy=%b want 0000/0/0",
               bus.gnt, bus.ins_vld, bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    do_reset();
    bus.data_in = 32'h1312_1110;
    bus.req     = 4'b1111;
    bus.last    = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      eg = 4'(1 << (k % N));
      ed = 8'(8'h10 + (k % N));
      tick();
      total++;
      if (bus.gnt !== eg)
        $display("FAIL rr_gnt%0d got %b want %b", k, bus.gnt, eg);
      else pass_cnt++;
      tick();
      total++;
      if (bus.gnt !== 4'b0000 || bus.ins !== ed ||
          bus.ins_vld !== 1'b1)
        $display("FAIL rr_gap%0d got gnt=%b ins=%h vld=%b want 0000/%h/1",
                 k, bus.gnt, bus.ins, bus.ins_vld, ed);
      else pass_cnt++;
    end
    bus.req  = '0;
    bus.last = '0;
    tick();
    tick();
  endtask

  task automatic test_preempt();
    int nbeats;
    logic [W-1:0] v;
    nbeats = 0;
    do_reset();
    bus.req  = 4'b0100;
    bus.last = 4'b0000;
    tick();
    total++;
    if (bus.gnt !== 4'b0100 || bus.ins_vld !== 1'b0)
      $display("FAIL pre_grant got gnt=%b vld=%b want 0100/0",
               bus.gnt, bus.ins_vld);
    else pass_cnt++;
    for (int b = 1; b <= MH; b++) begin
      v = 8'(8'hC0 + b);
      bus.data_in[23:16] = v;
      tick();
      if (bus.ins_vld === 1'b1) nbeats++;
      total++;
      if (bus.ins !== v || bus.ins_vld !== 1'b1)
        $display("FAIL pre_beat%0d got ins=%h vld=%b want %h/1",
                 b, bus.ins, bus.ins_vld, v);
      else pass_cnt++;
      total++;
      if (b < MH) begin
        if (bus.gnt !== 4'b0100 || bus.preempt !== 1'b0)
          $display("FAIL pre_hold%0d got gnt=%b pre=%b want 0100/0",
                   b, bus.gnt, bus.preempt);
        else pass_cnt++;
      end else begin
        if (bus.gnt !== 4'b0000 || bus.preempt !== 1'b1)
          $display("FAIL pre_fire got gnt=%b pre=%b want 0000/1",
                   bus.gnt, bus.preempt);
        else pass_cnt++;
      end
    end
    tick();
    total++;
    if (bus.gnt !== 4'b0100 || bus.preempt !== 1'b0 ||
        bus.ins_vld !== 1'b0)
      $display("FAIL pre_regrant got gnt=%b pre=%b vld=%b want 0100/0/0",
               bus.gnt, bus.preempt, bus.ins_vld);
    else pass_cnt++;
    total++;
    if (nbeats != MH)
      $display("FAIL pre_beats got %0d want %0d", nbeats, MH);
    else pass_cnt++;
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_drop();
    do_reset();
    bus.req  = 4'b0010;
    bus.last = 4'b0000;
    bus.data_in[15:8] = 8'h5A;
    tick();
    tick();
    bus.data_in[15:8] = 8'h5B;
    tick();
    total++;
    if (bus.gnt !== 4'b0010 || bus.ins !== 8'h5B ||
        bus.ins_vld !== 1'b1)
      $display("FAIL drop_beat2 got gnt=%b ins=%h vld=%b want 0010/5b/1",
               bus.gnt, bus.ins, bus.ins_vld);
    else pass_cnt++;
    bus.req = 4'b0000;
    bus.data_in[15:8] = 8'hEE;
    tick();
    total++;
    if (bus.gnt !== 4'b0000 || bus.ins_vld !== 1'b0 ||
        bus.preempt !== 1'b0 || bus.ins !== 8'h5B)
      $display("FAIL drop_rel got gnt=%b vld=%b pre=%b ins=%h want 0000/0/0/5b",
               bus.gnt, bus.ins_vld, bus.preempt, bus.ins);
    else pass_cnt++;
    bus.req  = 4'b1011;
    bus.last = 4'b1111;
    tick();
    total++;
    if (bus.gnt !== 4'b1000)
      $display("FAIL drop_ptr got gnt=%b want 1000", bus.gnt);
    else pass_cnt++;
    bus.req  = '0;
    bus.last = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req  = 4'b0001;
    bus.last = 4'b0000;
    bus.data_in[7:0] = 8'h77;
    tick();
    tick();
    total++;
    if (bus.ins !== 8'h77 || bus.ins_vld !== 1'b1)
      $display("FAIL rmid_beat got ins=%h vld=%b want 77/1",
               bus.ins, bus.ins_vld);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    total++;
    if (bus.gnt !== 4'b0000 || bus.ins !== 8'h00 ||
        bus.ins_vld !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL rmid_abort got gnt=%b ins=%h vld=%b busy=%b want 0000/00/0/0",
               bus.gnt, bus.ins, bus.ins_vld, bus.busy);
    else pass_cnt++;
    reset   = 1'b0;
    bus.req = 4'b0100;
    tick();
    total++;
    if (bus.gnt !== 4'b0100)
      $display("FAIL rmid_regrant got gnt=%b want 0100", bus.gnt);
    else pass_cnt++;
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_random();
    int           m_owner, m_ptr, m_beats;
    logic [W-1:0] m_ins;
    logic         m_vld, m_pre, rel;
    logic [N-1:0] r, l, eg;
    logic [N*W-1:0] d;
    int           wait_c[N];
    int           worst, errs;
    do_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_beats = 0;
    m_ins   = '0;
    m_vld   = 1'b0;
    m_pre   = 1'b0;
    r       = '0;
    worst   = 0;
    errs    = 0;
    for (int j = 0; j < N; j++) wait_c[j] = 0;
    for (int c = 0; c < 10000; c++) begin
      eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      total++;
      if (bus.gnt !== eg || !$onehot0(bus.gnt)) begin
        errs++;
        if (errs < 10)
          $display("FAIL rnd_gnt c=%0d got %b want %b", c, bus.gnt, eg);
      end else pass_cnt++;
      total++;
      if (bus.ins !== m_ins || bus.ins_vld !== m_vld) begin
        errs++;
        if (errs < 10)
          $display("FAIL rnd_ins c=%0d got %h/%b want %h/%b",
                   c, bus.ins, bus.ins_vld, m_ins, m_vld);
      end else pass_cnt++;
      total++;
      if (bus.preempt !== m_pre || bus.busy !== (m_owner >= 0)) begin
        errs++;
        if (errs < 10)
          $display("FAIL rnd_flags c=%0d got pre=%b busy=%b want %b/%b",
                   c, bus.preempt, bus.busy, m_pre, (m_owner >= 0));
      end else pass_cnt++;
      for (int j = 0; j < N; j++) begin
        if ($urandom_range(0, 3) == 0) r[j] = ~r[j];
        l[j] = ($urandom_range(0, 5) == 0);
      end
      d = $urandom;
      bus.req     = r;
      bus.last    = l;
      bus.data_in = d;
      for (int j = 0; j < N; j++) begin
        if (r[j] && bus.gnt[j] !== 1'b1) wait_c[j]++;
        else wait_c[j] = 0;
        if (wait_c[j] > worst) worst = wait_c[j];
      end
      @(posedge clk);
      m_pre = 1'b0;
      if (m_owner >= 0) begin
        rel = 1'b0;
        if (!r[m_owner]) begin
          m_vld = 1'b0;
          rel   = 1'b1;
        end else begin
          m_ins = d[m_owner*W +: W];
          m_vld = 1'b1;
          m_beats++;
          rel   = l[m_owner] || (m_beats == MH);
          m_pre = !l[m_owner] && (m_beats == MH);
        end
        if (rel) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end else begin
        m_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && r[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            m_beats = 0;
          end
        end
      end
      @(negedge clk);
    end
    total++;
    if (worst > N * (MH + 1))
      $display("FAIL rnd_starve got %0d cycles want <= %0d",
               worst, N * (MH + 1));
    else pass_cnt++;
    bus.req  = '0;
    bus.last = '0;
    tick();
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
